// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control definitions: operation classes from main control,
// R-type funct encodings and the 5-bit ALU operation codes.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    CLS_RTYPE  = 3'b000,
    CLS_ADD    = 3'b001,
    CLS_COMP   = 3'b010,
    CLS_AND    = 3'b011,
    CLS_XOR    = 3'b100,
    CLS_SUB    = 3'b101,
    CLS_SLT    = 3'b110,
    CLS_PASS_B = 3'b111
  } alu_class_e;

  localparam logic [5:0] FN_ADD  = 6'b000001;
  localparam logic [5:0] FN_COMP = 6'b000010;
  localparam logic [5:0] FN_AND  = 6'b000011;
  localparam logic [5:0] FN_XOR  = 6'b000100;
  localparam logic [5:0] FN_OR   = 6'b000101;
  localparam logic [5:0] FN_NOR  = 6'b000110;
  localparam logic [5:0] FN_SUB  = 6'b000111;
  localparam logic [5:0] FN_SLT  = 6'b001000;
  localparam logic [5:0] FN_SLL  = 6'b010001;
  localparam logic [5:0] FN_SRL  = 6'b010010;
  localparam logic [5:0] FN_SRA  = 6'b010011;
  localparam logic [5:0] FN_SLLV = 6'b010101;
  localparam logic [5:0] FN_SRLV = 6'b010110;
  localparam logic [5:0] FN_SRAV = 6'b010111;

  // Shift codes with this bit set take the shift amount from a register
  localparam int SHAMT_SRC = 4;

  typedef enum logic [4:0] {
    OP_NOP    = 5'b00000,
    OP_ADD    = 5'b00001,
    OP_SUB    = 5'b00010,
    OP_COMP   = 5'b00011,
    OP_AND    = 5'b00100,
    OP_OR     = 5'b00101,
    OP_XOR    = 5'b00110,
    OP_NOR    = 5'b00111,
    OP_SLL    = 5'b01000,
    OP_SRL    = 5'b01001,
    OP_SRA    = 5'b01010,
    OP_SLT    = 5'b01011,
    OP_PASS_B = 5'b01100,
    OP_SLLV   = 5'b11000,
    OP_SRLV   = 5'b11001,
    OP_SRAV   = 5'b11010
  } alu_op_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of {ALU class, funct} into an ALU operation code
// plus an illegal-funct flag for unrecognised R-type encodings.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu,
  input  logic [5:0] funct,
  output logic [4:0] code,
  output logic       illegal
);

  always_comb begin
    code    = OP_NOP;
    illegal = 1'b0;
    case (alu)
      CLS_RTYPE: begin
        case (funct)
          FN_ADD:  code = OP_ADD;
          FN_COMP: code = OP_COMP;
          FN_AND:  code = OP_AND;
          FN_XOR:  code = OP_XOR;
          FN_OR:   code = OP_OR;
          FN_NOR:  code = OP_NOR;
          FN_SUB:  code = OP_SUB;
          FN_SLT:  code = OP_SLT;
          FN_SLL:  code = OP_SLL;
          FN_SRL:  code = OP_SRL;
          FN_SRA:  code = OP_SRA;
          FN_SLLV: code = OP_SLLV;
          FN_SRLV: code = OP_SRLV;
          FN_SRAV: code = OP_SRAV;
          default: illegal = 1'b1;
        endcase
      end
      CLS_ADD:    code = OP_ADD;
      CLS_COMP:   code = OP_COMP;
      CLS_AND:    code = OP_AND;
      CLS_XOR:    code = OP_XOR;
      CLS_SUB:    code = OP_SUB;
      CLS_SLT:    code = OP_SLT;
      CLS_PASS_B: code = OP_PASS_B;
      default:    code = OP_NOP;
    endcase
  end

endmodule

// File: rtl/alu_control_unit.sv
// Registered ALU-control decoder: one cycle of latency from {ALU, funct}
// to {out, illegal}, with synchronous active-low reset to NOP.
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ALU,
  input  logic [5:0] funct,
  output logic [4:0] out,
  output logic       illegal
);

  logic [4:0] code_d;
  logic       illegal_d;

  alu_ctrl_decode u_decode (
    .alu     (ALU),
    .funct   (funct),
    .code    (code_d),
    .illegal (illegal_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out     <= OP_NOP;
      illegal <= 1'b0;
    end else begin
      out     <= code_d;
      illegal <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Scoreboard bench for alu_control_unit: stimulus pushes hand-computed
// expectations, a monitor pops and compares one per clock.
module tb_alu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ALU = 3'b000;
  logic [5:0] funct = 6'b000000;
  logic [4:0] out;
  logic       illegal;

  typedef struct {
    logic [4:0] out;
    logic       ill;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  alu_control_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ALU     (ALU),
    .funct   (funct),
    .out     (out),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Hand-written R-type table, returns {illegal, code}
  function automatic logic [5:0] rtype_ref(input logic [5:0] f);
    case (f)
      6'b000001: return {1'b0, 5'b00001};
      6'b000010: return {1'b0, 5'b00011};
      6'b000011: return {1'b0, 5'b00100};
      6'b000100: return {1'b0, 5'b00110};
      6'b000101: return {1'b0, 5'b00101};
      6'b000110: return {1'b0, 5'b00111};
      6'b000111: return {1'b0, 5'b00010};
      6'b001000: return {1'b0, 5'b01011};
      6'b010001: return {1'b0, 5'b01000};
      6'b010010: return {1'b0, 5'b01001};
      6'b010011: return {1'b0, 5'b01010};
      6'b010101: return {1'b0, 5'b11000};
      6'b010110: return {1'b0, 5'b11001};
      6'b010111: return {1'b0, 5'b11010};
      default:   return {1'b1, 5'b00000};
    endcase
  endfunction

  task automatic drive(input logic r, input logic [2:0] a, input logic [5:0] f,
                       input logic [4:0] eo, input logic ei, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    ALU   = a;
    funct = f;
    e.out  = eo;
    e.ill  = ei;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (out === e.out && illegal === e.ill)
        passed++;
      else
        $display("FAIL %s: got out=%b illegal=%b, expected out=%b illegal=%b",
                 e.name, out, illegal, e.out, e.ill);
    end
  end

  logic [5:0] ref_v;
  logic [2:0] cls_a;
  logic [4:0] cls_o;

  initial begin
    // Reset with a live non-R input, then release
    drive(1'b0, 3'b001, 6'b010101, 5'b00000, 1'b0, "reset_1");
    drive(1'b0, 3'b001, 6'b010101, 5'b00000, 1'b0, "reset_2");
    drive(1'b1, 3'b001, 6'b010101, 5'b00001, 1'b0, "reset_release");

    // Non-R class ignores funct
    drive(1'b1, 3'b001, 6'b111111, 5'b00001, 1'b0, "add_ignores_funct");

    // Variable / immediate shifts
    drive(1'b1, 3'b000, 6'b010101, 5'b11000, 1'b0, "sllv");
    drive(1'b1, 3'b000, 6'b010011, 5'b01010, 1'b0, "sra");
    drive(1'b1, 3'b000, 6'b010111, 5'b11010, 1'b0, "srav");

    // Full R-type sweep
    for (int i = 0; i < 64; i++) begin
      ref_v = rtype_ref(6'(i));
      drive(1'b1, 3'b000, 6'(i), ref_v[4:0], ref_v[5], $sformatf("rtype_f%0d", i));
    end

    // Class sweep with random funct
    for (int c = 2; c < 8; c++) begin
      cls_a = 3'(c);
      case (cls_a)
        3'b010:  cls_o = 5'b00011;
        3'b011:  cls_o = 5'b00100;
        3'b100:  cls_o = 5'b00110;
        3'b101:  cls_o = 5'b00010;
        3'b110:  cls_o = 5'b01011;
        default: cls_o = 5'b01100;
      endcase
      drive(1'b1, cls_a, 6'($urandom_range(63)), cls_o, 1'b0, $sformatf("class_%0d", c));
    end

    // Back-to-back changes with a one-cycle reset in the middle
    drive(1'b1, 3'b000, 6'b000111, 5'b00010, 1'b0, "stream_sub");
    drive(1'b1, 3'b000, 6'b000000, 5'b00000, 1'b1, "stream_illegal");
    drive(1'b1, 3'b111, 6'b000000, 5'b01100, 1'b0, "stream_passb");
    drive(1'b0, 3'b000, 6'b111111, 5'b00000, 1'b0, "stream_midreset");
    drive(1'b1, 3'b000, 6'b111111, 5'b00000, 1'b1, "stream_after_reset");
    drive(1'b1, 3'b000, 6'b010001, 5'b01000, 1'b0, "stream_sll");
    drive(1'b1, 3'b011, 6'b010110, 5'b00100, 1'b0, "stream_and");
    drive(1'b1, 3'b000, 6'b010110, 5'b11001, 1'b0, "stream_srlv");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Registered ALU-control decoder for the lab's single-cycle/multicycle datapath; sits between the main control unit and the ALU.
- Combines the 3-bit ALU operation class from main control with the 6-bit instruction funct field to produce a 5-bit ALU operation code.
- Output is registered, one clock of latency, and includes an illegal-funct flag.

Parameters:
- None. All widths are fixed: ALU op 3, funct 6, out 5.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  synchronous reset, active low.
- ALU  input  3  ALU operation class from main control.
- funct  input  6  instruction funct field; used only when ALU=000.
- out  output  5  registered ALU operation code.
- illegal  output  1  registered flag; 1 when ALU=000 and funct is not in the R-type table.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, out=00000 (NOP) and illegal=0. Reset has priority over decode.
- Otherwise, on every rising edge, out and illegal load the decode of the current {ALU, funct}.
- Latency: exactly 1 cycle. There is no enable, so the output follows the input each cycle.
- Output code set:
  - 00000 NOP
  - 00001 ADD
  - 00010 SUB
  - 00011 COMP (two's complement of B)
  - 00100 AND
  - 00101 OR
  - 00110 XOR
  - 00111 NOR
  - 01000 SLL by shamt
  - 01001 SRL by shamt
  - 01010 SRA by shamt
  - 01011 SLT
  - 01100 PASS_B
  - 11000 SLLV
  - 11001 SRLV
  - 11010 SRAV
  - For shift codes, out[4]=1 selects a register-supplied shift amount and out[4]=0 selects shamt. Codes not listed are never produced.
- ALU class decode (funct ignored unless ALU=000):
  - 000 R-type, decoded via funct (below)
  - 001 ADD (addi/lw/sw)
  - 010 COMP (compi)
  - 011 AND (andi)
  - 100 XOR (xori)
  - 101 SUB (branch compare)
  - 110 SLT (slti)
  - 111 PASS_B (lui/move)
- R-type funct decode (ALU=000):
  - 000001 ADD
  - 000010 COMP
  - 000011 AND
  - 000100 XOR
  - 000101 OR
  - 000110 NOR
  - 000111 SUB
  - 001000 SLT
  - 010001 SLL
  - 010010 SRL
  - 010011 SRA
  - 010101 SLLV
  - 010110 SRLV
  - 010111 SRAV
- Any other funct with ALU=000 gives out=00000 and illegal=1.
- illegal=0 for every ALU≠000, regardless of funct.
- X/Z on inputs is not defined; the bench drives known values only.
- Reset asserted mid-stream: the output goes to 00000/0 at the next edge. After release, the first edge loads the current decode.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - enum/localparams for the ALU class (8 values)
  - funct constants (14 values)
  - the 5-bit ALU operation code enum with the SHAMT_SRC bit position (4)
- The ALU datapath module imports the same package.
- One natural sub-module: alu_ctrl_decode, purely combinational, taking {ALU, funct} to {code, illegal}.
- The top alu_control_unit instantiates it and adds the reset-capable output register.

Test Plan:
- Reset: rst_n=0 for 2 edges with ALU=001, funct=010101 -> out=00000, illegal=0; release -> next edge out=00001.
- Non-R class ignores funct: ALU=001, funct=010101 -> out=00001 after 1 edge; ALU=001, funct=111111 -> out=00001, illegal=0.
- R-type variable shift: ALU=000, funct=010101 -> out=11000 after 1 edge; funct=010011 -> 01010; funct=010111 -> 11010.
- Full R-type sweep: ALU=000, all 64 funct values -> the 14 listed give the table codes with illegal=0; the other 50 give 00000 with illegal=1 (e.g. 000000, 111111).
- Class sweep: ALU=010..111 with random funct -> 00011, 00100, 00110, 00010, 01011, 01100 respectively, illegal=0.
- Latency/mid-reset: change inputs every cycle and check each out equals the decode of the inputs one cycle earlier; assert rst_n=0 for one cycle mid-stream -> exactly one 00000/0 sample, then tracking resumes.
